// File: rtl/credit_tx.sv
// rtl/credit_tx.sv - credit-based link transmitter with registered valid/data toward a remote buffer
// Optional feature macro: CREDIT_TX_STALL_CNT_EN (adds 16-bit saturating stall_cnt output)
module credit_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDITS    = 8,
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upstream_vld,
  output logic                  upstream_rdy,
  input  logic [DATA_WIDTH-1:0] upstream_data,
  output logic                  tx_vld,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  credit_rtn,
  output logic [CNT_WIDTH-1:0]  credit_cnt,
  output logic                  tx_idle,
  output logic                  credit_ovf
`ifdef CREDIT_TX_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  idle_q, idle_d;
  logic                  ovf_q, ovf_d;
  logic                  push;
`ifdef CREDIT_TX_STALL_CNT_EN
  logic [15:0]           stall_q, stall_d;
`endif

  // Next-state: INIT loads the full credit budget, RUN sends beats and tracks credits.
  // ready and idle are computed from next-state values so they leave as plain flops.
  always_comb begin
    push    = upstream_vld && rdy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q;
`ifdef CREDIT_TX_STALL_CNT_EN
    stall_d = stall_q;
`endif
    if (state_q == ST_INIT) begin
      // credit_rtn is ignored here: the load value wins
      state_d = ST_RUN;
      cnt_d   = FULL;
    end else begin
      vld_d = push;
      if (push) begin
        data_d = upstream_data;
      end
      if (push && !credit_rtn) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end else if (!push && credit_rtn) begin
        // a return while already full is a protocol error; hold the count
        if (cnt_q == FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
`ifdef CREDIT_TX_STALL_CNT_EN
      if (upstream_vld && (cnt_q == '0) && (stall_q != 16'hFFFF)) begin
        stall_d = stall_q + 16'd1;
      end
`endif
    end
    rdy_d  = (state_d == ST_RUN) && (cnt_d != '0);
    idle_d = (state_d == ST_RUN) && (cnt_d == FULL) && !vld_d;
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      idle_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CREDIT_TX_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
`ifdef CREDIT_TX_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign upstream_rdy = rdy_q;
  assign tx_vld       = vld_q;
  assign tx_data      = data_q;
  assign credit_cnt   = cnt_q;
  assign tx_idle      = idle_q;
  assign credit_ovf   = ovf_q;
`ifdef CREDIT_TX_STALL_CNT_EN
  assign stall_cnt    = stall_q;
`endif

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmit end of a credit-based link; peer of the receive-side elastic buffers (full-bandwidth FIFO) in the same datapath.
- Accepts a valid/ready stream upstream and drives a registered, non-backpressured valid/data link toward a remote receive buffer of CREDITS entries.
- Tracks free remote entries with a credit counter: one credit is consumed per beat sent and one is restored per credit_rtn pulse.
- Sustains one beat per cycle while credits are available.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- CREDITS, 8, depth of the remote receive buffer. Also the credit count loaded after reset. Legal range is 1 or more.
- CNT_WIDTH, $clog2(CREDITS+1), width of the credit counter. Derived; not to be overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high.
- upstream_vld  input  1  upstream beat valid.
- upstream_rdy  output  1  block can accept a beat this cycle.
- upstream_data  input  DATA_WIDTH  upstream payload.
- tx_vld  output  1  link beat valid. Registered, one cycle per beat.
- tx_data  output  DATA_WIDTH  link payload. Registered.
- credit_rtn  input  1  one pulse returns one credit (receiver freed one entry).
- credit_cnt  output  CNT_WIDTH  current free remote entries.
- tx_idle  output  1  high when credit_cnt == CREDITS and tx_vld == 0.
- credit_ovf  output  1  sticky error: a credit was returned while already holding CREDITS.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=INIT, credit_cnt=0, tx_vld=0, tx_data=0, credit_ovf=0, upstream_rdy=0, tx_idle=0.
- State machine:
  - INIT, for exactly one cycle after rst deasserts: credit_cnt loads CREDITS, upstream_rdy=0. Next state is RUN.
  - RUN: normal operation. Remains in RUN until rst. No other states.
- upstream_rdy = (state==RUN) && (credit_cnt != 0). Driven from registers only; never depends on upstream_vld.
- push = upstream_vld && upstream_rdy.
- Push latency: one cycle. After a push, tx_vld=1 and tx_data=upstream_data on the next cycle. Without a push, tx_vld=0 next cycle and tx_data holds its last value.
- Credit update in RUN: next credit_cnt = credit_cnt - push + credit_rtn.
  - Push and credit_rtn in the same cycle: count unchanged.
  - credit_cnt==0 with credit_rtn=1: count becomes 1 and upstream_rdy rises the following cycle. No same-cycle bypass.
  - credit_rtn=1 while credit_cnt==CREDITS and no push: count holds at CREDITS and credit_ovf sets. credit_ovf clears only on rst.
  - credit_cnt never underflows, because upstream_rdy is 0 at zero credits.
- credit_rtn during INIT is ignored; the load value wins.
- Full bandwidth: back-to-back pushes every cycle while credit_cnt > 0.
- Reset mid-stream: on the next edge all state returns to reset values. In-flight beats and outstanding credits are discarded; the receiver must be reset together with this block.

Optional Feature:
- Macro: CREDIT_TX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Increments each RUN cycle where upstream_vld=1 and credit_cnt==0.
  - Saturates at 0xFFFF and resets to 0 on rst.
- Undefined: port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset/init (CREDITS=4): hold rst 2 cycles, then release. Cycle 1: upstream_rdy=0, credit_cnt=0. Cycle 2: credit_cnt=4, upstream_rdy=1, tx_idle=1.
- Burst to exhaustion: upstream_vld=1 with data 0x10..0x15, no credit_rtn.
  - 4 pushes on consecutive cycles; tx_data=0x10..0x13 each one cycle later.
  - Then credit_cnt=0, upstream_rdy=0, and 0x14 is held upstream.
- Recovery: from zero credits, pulse credit_rtn once. Next cycle credit_cnt=1 and upstream_rdy=1; 0x14 is pushed and appears on tx the following cycle; credit_cnt returns to 0.
- Steady state: credit_cnt=2, continuous push with credit_rtn=1 every cycle for 20 cycles. credit_cnt stays 2; 20 consecutive tx_vld beats with data in order.
- Overflow: idle at credit_cnt=4, pulse credit_rtn. credit_cnt stays 4, credit_ovf=1 and stays 1 until rst.
- Mid-stream reset: assert rst while tx_vld=1 and credit_cnt=1. Next cycle tx_vld=0, credit_cnt=0, credit_ovf=0; INIT sequence repeats. With CREDIT_TX_STALL_CNT_EN defined: 5 stalled cycles at zero credits give stall_cnt=5.
